// File: rtl/ts_scurve_pkg.sv
// ts_scurve_pkg: FSM state encoding and default widths
// for the multi-channel s-curve threshold-scan engine.
package ts_scurve_pkg;

  localparam int N_CH_D       = 4;
  localparam int TH_W_D       = 10;
  localparam int ACC_W_D      = 12;
  localparam int NPUL_W_D     = 12;
  localparam int SETTLE_CYC_D = 16;
  localparam int WIN_CYC_D    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    INJ,
    WIN,
    REPORT,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/ts_scurve_ch_acc.sv
// ts_scurve_ch_acc: per-channel edge detect, window hit flag and
// saturating counter; Th50 search built only with TS_SCURVE_TH50_EN.
module ts_scurve_ch_acc
  import ts_scurve_pkg::*;
#(
  parameter int TH_W   = TH_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int NPUL_W = NPUL_W_D
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              discri_i,
  input  logic              win_i,
  input  logic              win_last_i,
  input  logic              clr_i,
  input  logic              rpt_i,
  input  logic              start_i,
  input  logic [TH_W-1:0]   th_i,
  input  logic [NPUL_W-1:0] npul_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [TH_W-1:0]   th50_o,
  output logic              th50_v_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic             prev_q;
  logic             hit_q, hit_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             rise;

  assign rise = discri_i & ~prev_q;

  always_comb begin
    hit_d = hit_q;
    acc_d = acc_q;
    if (clr_i) begin
      hit_d = 1'b0;
      acc_d = '0;
    end else if (win_i) begin
      hit_d = hit_q | rise;
      if (win_last_i) begin
        if (hit_d && acc_q != ACC_MAX)
          acc_d = acc_q + 1'b1;
        hit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      hit_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      prev_q <= discri_i;
      hit_q  <= hit_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

`ifdef TS_SCURVE_TH50_EN
  localparam int CW = ACC_W + NPUL_W + 1;

  logic [CW-1:0]   dbl, npx;
  logic [TH_W-1:0] th50_q;
  logic            v_q;

  // acc_d already holds the final count of the step on REPORT entry
  assign dbl = CW'(acc_d) << 1;
  assign npx = CW'(npul_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      th50_q <= '0;
      v_q    <= 1'b0;
    end else if (rpt_i && !v_q && dbl >= npx) begin
      th50_q <= th_i;
      v_q    <= 1'b1;
    end
  end

  assign th50_o   = th50_q;
  assign th50_v_o = v_q;
`else
  logic unused_th50;
  assign unused_th50 = ^{rpt_i, start_i, th_i, npul_i};
  assign th50_o      = '0;
  assign th50_v_o    = 1'b0;
`endif

endmodule

// File: rtl/ts_scurve_mc.sv
// ts_scurve_mc: threshold-scan FSM, TH stepping and result port.
// Optional per-channel Th50 search: define TS_SCURVE_TH50_EN.
module ts_scurve_mc
  import ts_scurve_pkg::*;
#(
  parameter int N_CH       = N_CH_D,
  parameter int TH_W       = TH_W_D,
  parameter int ACC_W      = ACC_W_D,
  parameter int NPUL_W     = NPUL_W_D,
  parameter int SETTLE_CYC = SETTLE_CYC_D,
  parameter int WIN_CYC    = WIN_CYC_D
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic [TH_W-1:0]        ThStart,
  input  logic [TH_W-1:0]        ThStop,
  input  logic [TH_W-1:0]        ThStep,
  input  logic [NPUL_W-1:0]      NPulse,
  input  logic [N_CH-1:0]        DiscriPul,
  output logic [TH_W-1:0]        TH,
  output logic                   QinjPul,
  output logic                   ScanBusy,
  output logic                   ResValid,
  input  logic                   ResReady,
  output logic [TH_W-1:0]        ResTH,
  output logic [N_CH*ACC_W-1:0]  ResAcc,
  output logic                   Done,
  output logic [N_CH*TH_W-1:0]   Th50,
  output logic [N_CH-1:0]        Th50Valid
);

  localparam int CYC_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX) + 1;
  localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'(WIN_CYC - 1);

  state_e            state_q;
  logic [TH_W-1:0]   th_q, stop_q, step_q;
  logic [NPUL_W-1:0] npul_q, pcnt_q;
  logic [CYC_W-1:0]  cyc_q;
  logic              qinj_q, busy_q, rv_q, done_q;
  logic [TH_W:0]     sum_d;
  logic              start_ok, settle_end, win_act, win_end;
  logic              more, over, ent_settle, ent_rpt;

  assign start_ok   = state_q == IDLE && Start && !Abort;
  assign settle_end = state_q == SETTLE && cyc_q == SET_LAST;
  assign win_act    = state_q == WIN;
  assign win_end    = win_act && cyc_q == WIN_LAST;
  assign more       = pcnt_q < npul_q;
  assign sum_d      = {1'b0, th_q} + {1'b0, step_q};
  assign over       = sum_d[TH_W] || sum_d > {1'b0, stop_q};
  assign ent_settle = start_ok || (state_q == NEXT && !over && !Abort);
  assign ent_rpt    = !Abort &&
                      ((settle_end && npul_q == '0) || (win_end && !more));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      th_q    <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      npul_q  <= '0;
      pcnt_q  <= '0;
      cyc_q   <= '0;
      qinj_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (Abort) begin
      state_q <= IDLE;
      qinj_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      qinj_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start_ok) begin
          th_q    <= ThStart;
          stop_q  <= ThStop;
          step_q  <= (ThStep == '0) ? TH_W'(1) : ThStep;
          npul_q  <= NPulse;
          cyc_q   <= '0;
          pcnt_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= SETTLE;
        end
        SETTLE: begin
          cyc_q <= cyc_q + 1'b1;
          if (settle_end) begin
            cyc_q <= '0;
            if (npul_q == '0) begin
              rv_q    <= 1'b1;
              state_q <= REPORT;
            end else begin
              qinj_q  <= 1'b1;
              pcnt_q  <= pcnt_q + 1'b1;
              state_q <= INJ;
            end
          end
        end
        INJ: begin
          cyc_q   <= '0;
          state_q <= WIN;
        end
        WIN: begin
          cyc_q <= cyc_q + 1'b1;
          if (win_end) begin
            cyc_q <= '0;
            if (more) begin
              qinj_q  <= 1'b1;
              pcnt_q  <= pcnt_q + 1'b1;
              state_q <= INJ;
            end else begin
              rv_q    <= 1'b1;
              state_q <= REPORT;
            end
          end
        end
        REPORT: if (ResReady) begin
          rv_q    <= 1'b0;
          state_q <= NEXT;
        end
        NEXT: if (over) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          th_q    <= sum_d[TH_W-1:0];
          cyc_q   <= '0;
          pcnt_q  <= '0;
          state_q <= SETTLE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ts_scurve_ch_acc #(
      .TH_W   (TH_W),
      .ACC_W  (ACC_W),
      .NPUL_W (NPUL_W)
    ) u_acc (
      .clk_i      (CLK),
      .rst_i      (RST),
      .discri_i   (DiscriPul[i]),
      .win_i      (win_act),
      .win_last_i (win_end),
      .clr_i      (ent_settle),
      .rpt_i      (ent_rpt),
      .start_i    (start_ok),
      .th_i       (th_q),
      .npul_i     (npul_q),
      .acc_o      (ResAcc[i*ACC_W +: ACC_W]),
      .th50_o     (Th50[i*TH_W +: TH_W]),
      .th50_v_o   (Th50Valid[i])
    );
  end

  assign TH       = th_q;
  assign QinjPul  = qinj_q;
  assign ScanBusy = busy_q;
  assign ResValid = rv_q;
  assign ResTH    = th_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_ts_scurve_mc.sv
// tb_ts_scurve_mc: directed scenarios for ts_scurve_mc with a
// pulse-synchronous discriminator model; a 3-bit-acc copy runs alongside.
module tb_ts_scurve_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rdy = 1'b1;
  logic [9:0]  th_start = '0, th_stop = '0, th_step = '0;
  logic [11:0] npul = '0;
  logic [3:0]  discri = '0;

  logic [9:0]  th, resth;
  logic        qinj, busy, rv, done;
  logic [47:0] resacc;
  logic [39:0] th50;
  logic [3:0]  th50v;

  logic [9:0]  sat_unused_th, sat_unused_resth;
  logic        sat_unused_qinj, sat_unused_busy, sat_unused_rv, sat_unused_done;
  logic [11:0] s_resacc;
  logic [39:0] sat_unused_th50;
  logic [3:0]  sat_unused_th50v;

  int total = 0;
  int bad = 0;
  logic [15:0] pat [4];
  int thmin [4];
  int thmax [4];
  int since = 1000;
  int qcnt = 0;
  int ndone = 0;
  int rcnt = 0;

  ts_scurve_mc dut (
    .CLK(clk), .RST(rst), .Start(start), .Abort(abort),
    .ThStart(th_start), .ThStop(th_stop), .ThStep(th_step),
    .NPulse(npul), .DiscriPul(discri), .TH(th), .QinjPul(qinj),
    .ScanBusy(busy), .ResValid(rv), .ResReady(rdy), .ResTH(resth),
    .ResAcc(resacc), .Done(done), .Th50(th50), .Th50Valid(th50v)
  );

  ts_scurve_mc #(.ACC_W(3)) dut_sat (
    .CLK(clk), .RST(rst), .Start(start), .Abort(abort),
    .ThStart(th_start), .ThStop(th_stop), .ThStep(th_step),
    .NPulse(npul), .DiscriPul(discri), .TH(sat_unused_th),
    .QinjPul(sat_unused_qinj), .ScanBusy(sat_unused_busy),
    .ResValid(sat_unused_rv), .ResReady(rdy), .ResTH(sat_unused_resth),
    .ResAcc(s_resacc), .Done(sat_unused_done), .Th50(sat_unused_th50),
    .Th50Valid(sat_unused_th50v)
  );

  always #5 clk = ~clk;

  // discriminator: fires at cycle offsets after each QinjPul given by pat
  always @(posedge clk) begin
    #1;
    if (qinj) since = 0;
    else if (since < 1000) since = since + 1;
    for (int i = 0; i < 4; i++)
      discri[i] = (since < 16) && pat[i][since[3:0]] &&
                  (int'(th) >= thmin[i]) && (int'(th) < thmax[i]);
  end

  always @(negedge clk) begin
    if (qinj) qcnt = qcnt + 1;
    if (done) ndone = ndone + 1;
    if (rv && rdy) rcnt = rcnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input logic [15:0] p0, p1, p2, p3);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    for (int i = 0; i < 4; i++) begin
      thmin[i] = 0;
      thmax[i] = 1024;
    end
  endtask

  // config is scrambled after Start to show it was latched
  task automatic start_scan(input int s, e, st, np);
    @(posedge clk); #1;
    th_start = 10'(s); th_stop = 10'(e); th_step = 10'(st);
    npul = 12'(np); qcnt = 0; start = 1'b1;
    tick(1);
    start = 1'b0;
    th_start = 10'd5; th_stop = 10'd0; th_step = 10'd7; npul = 12'd3;
  endtask

  task automatic get_res(output logic [9:0] t, output logic [47:0] a,
                         output logic [11:0] sa, output int q,
                         output bit ok);
    ok = 1'b0; t = '0; a = '0; sa = '0; q = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (rv) begin
        ok = 1'b1; t = resth; a = resacc; sa = s_resacc;
        q = qcnt; qcnt = 0;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    total++;
    if (th !== 10'd0) begin
      bad++; $display("FAIL reset_th: got %0d want 0", th);
    end
    total++;
    if ({qinj, busy, rv, done} !== 4'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0000", {qinj, busy, rv, done});
    end
    total++;
    if ({resth, resacc} !== 58'd0) begin
      bad++; $display("FAIL reset_res: got %h want 0", {resth, resacc});
    end
    total++;
    if ({th50, th50v} !== 44'd0) begin
      bad++; $display("FAIL reset_th50: got %h want 0", {th50, th50v});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_scan;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    int q, d0, r0; bit ok;
    set_pat(16'h0008, 16'h0000, 16'h0000, 16'h0000);
    d0 = ndone; r0 = rcnt;
    start_scan(100, 104, 2, 10);
    for (int k = 0; k < 3; k++) begin
      get_res(t, a, sa, q, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_timeout: step %0d no result", k); end
      total++;
      if (t !== 10'(100 + 2 * k)) begin
        bad++; $display("FAIL basic_th: got %0d want %0d", t, 100 + 2 * k);
      end
      total++;
      if (a[23:0] !== {12'd0, 12'd10}) begin
        bad++; $display("FAIL basic_acc: got %h want 00000a", a[23:0]);
      end
      total++;
      if (q !== 10) begin
        bad++; $display("FAIL basic_qinj: got %0d want 10", q);
      end
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_idle: busy stuck"); end
    total++;
    if (ndone - d0 !== 1) begin
      bad++; $display("FAIL basic_done: got %0d want 1", ndone - d0);
    end
    total++;
    if (rcnt - r0 !== 3) begin
      bad++; $display("FAIL basic_count: got %0d want 3", rcnt - r0);
    end
  endtask

  task automatic test_backpressure;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    logic [47:0] a0; int q; bit ok;
    set_pat(16'h0008, 16'h0000, 16'h0000, 16'h0000);
    rdy = 1'b0;
    start_scan(200, 201, 1, 2);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (rv) ok = 1'b1;
    end
    a0 = resacc;
    total++;
    if (!ok || resth !== 10'd200 || a0[11:0] !== 12'd2) begin
      bad++; $display("FAIL bp_first: got th=%0d acc0=%0d want 200/2", resth, a0[11:0]);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({rv, resth, resacc, th} !== {1'b1, 10'd200, a0, 10'd200}) begin
        bad++;
        $display("FAIL bp_hold: got v=%b th=%0d TH=%0d want 1/200/200", rv, resth, th);
      end
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rv !== 1'b0 || th !== 10'd200) begin
      bad++; $display("FAIL bp_xfer: got v=%b TH=%0d want 0/200", rv, th);
    end
    get_res(t, a, sa, q, ok);
    total++;
    if (!ok || t !== 10'd201 || a[11:0] !== 12'd2) begin
      bad++; $display("FAIL bp_second: got th=%0d acc0=%0d want 201/2", t, a[11:0]);
    end
    wait_idle(ok);
  endtask

  task automatic test_boundaries;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    int q, r0, d0; bit ok;
    set_pat(16'h0008, 16'h0008, 16'h0000, 16'h0000);
    start_scan(300, 300, 1, 0);
    get_res(t, a, sa, q, ok);
    total++;
    if (!ok || t !== 10'd300 || a !== 48'd0 || q !== 0) begin
      bad++; $display("FAIL npul0: got th=%0d acc=%h qinj=%0d want 300/0/0", t, a, q);
    end
    wait_idle(ok);
    r0 = rcnt;
    start_scan(10, 12, 0, 1);
    for (int k = 0; k < 3; k++) begin
      get_res(t, a, sa, q, ok);
      total++;
      if (!ok || t !== 10'(10 + k)) begin
        bad++; $display("FAIL step0: got %0d want %0d", t, 10 + k);
      end
    end
    wait_idle(ok);
    total++;
    if (rcnt - r0 !== 3) begin
      bad++; $display("FAIL step0_count: got %0d want 3", rcnt - r0);
    end
    r0 = rcnt; d0 = ndone;
    start_scan(1020, 1023, 8, 1);
    get_res(t, a, sa, q, ok);
    total++;
    if (!ok || t !== 10'd1020) begin
      bad++; $display("FAIL ovf_th: got %0d want 1020", t);
    end
    wait_idle(ok);
    total++;
    if (rcnt - r0 !== 1 || ndone - d0 !== 1) begin
      bad++;
      $display("FAIL ovf_count: got res=%0d done=%0d want 1/1", rcnt - r0, ndone - d0);
    end
    r0 = rcnt;
    start_scan(500, 400, 1, 1);
    get_res(t, a, sa, q, ok);
    wait_idle(ok);
    total++;
    if (t !== 10'd500 || rcnt - r0 !== 1) begin
      bad++; $display("FAIL rev_range: got th=%0d n=%0d want 500/1", t, rcnt - r0);
    end
  endtask

  task automatic test_window_edges;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    int q; bit ok;
    set_pat(16'h0001, 16'h0100, 16'h0054, 16'h0200);
    start_scan(400, 400, 1, 4);
    get_res(t, a, sa, q, ok);
    total++;
    if (!ok || a !== {12'd0, 12'd4, 12'd4, 12'd0}) begin
      bad++; $display("FAIL win_edges: got %h want 000004004000", a);
    end
    wait_idle(ok);
  endtask

  task automatic test_saturation;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    int q; bit ok;
    set_pat(16'h0008, 16'h0000, 16'h0000, 16'h0000);
    start_scan(50, 50, 1, 10);
    get_res(t, a, sa, q, ok);
    total++;
    if (!ok || sa[2:0] !== 3'd7) begin
      bad++; $display("FAIL sat_acc: got %0d want 7", sa[2:0]);
    end
    total++;
    if (a[11:0] !== 12'd10) begin
      bad++; $display("FAIL sat_ref: got %0d want 10", a[11:0]);
    end
    wait_idle(ok);
  endtask

  task automatic test_abort;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    int q, d0; bit ok, ok2;
    set_pat(16'h0008, 16'h0000, 16'h0000, 16'h0000);
    d0 = ndone;
    start_scan(600, 610, 1, 1);
    get_res(t, a, sa, q, ok);
    get_res(t, a, sa, q, ok2);
    total++;
    if (!ok || !ok2 || t !== 10'd601) begin
      bad++; $display("FAIL abort_pre: got th=%0d want 601", t);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, rv, qinj} !== 3'b000 || th !== 10'd601) begin
      bad++; $display("FAIL abort_idle: got ctl=%b TH=%0d want 000/601", {busy, rv, qinj}, th);
    end
    tick(40);
    @(negedge clk);
    total++;
    if (ndone !== d0 || busy !== 1'b0 || th !== 10'd601) begin
      bad++; $display("FAIL abort_quiet: got done=%0d busy=%b want 0/0", ndone - d0, busy);
    end
    th_start = 10'd800; th_stop = 10'd800; npul = 12'd1;
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(20);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || th !== 10'd601) begin
      bad++; $display("FAIL start_abort: got busy=%b TH=%0d want 0/601", busy, th);
    end
    start_scan(700, 700, 1, 1);
    get_res(t, a, sa, q, ok);
    total++;
    if (!ok || t !== 10'd700) begin
      bad++; $display("FAIL restart: got %0d want 700", t);
    end
    wait_idle(ok);
  endtask

  task automatic test_th50;
    logic [9:0] t; logic [47:0] a; logic [11:0] sa;
    int q; bit ok;
    set_pat(16'h0008, 16'h0008, 16'h0000, 16'h0008);
    thmax[0] = 103;
    thmin[1] = 104;
    start_scan(100, 106, 1, 8);
    for (int k = 0; k < 7; k++) get_res(t, a, sa, q, ok);
    wait_idle(ok);
`ifdef TS_SCURVE_TH50_EN
    total++;
    if (th50v !== 4'b1011) begin
      bad++; $display("FAIL th50_valid: got %b want 1011", th50v);
    end
    total++;
    if (th50 !== {10'd100, 10'd0, 10'd104, 10'd100}) begin
      bad++; $display("FAIL th50_val: got %h want %h", th50, {10'd100, 10'd0, 10'd104, 10'd100});
    end
    start_scan(100, 100, 1, 4);
    @(negedge clk);
    total++;
    if ({th50, th50v} !== 44'd0) begin
      bad++; $display("FAIL th50_clear: got %h want 0", {th50, th50v});
    end
    wait_idle(ok);
`else
    total++;
    if ({th50, th50v} !== 44'd0) begin
      bad++; $display("FAIL th50_tied: got %h want 0", {th50, th50v});
    end
`endif
  endtask

  task automatic test_rst_mid;
    int d0;
    set_pat(16'h0008, 16'h0008, 16'h0008, 16'h0008);
    d0 = ndone;
    start_scan(900, 910, 1, 4);
    tick(30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, rv, qinj} !== 3'b000 || th !== 10'd0 || resacc !== 48'd0) begin
      bad++; $display("FAIL rst_mid: got ctl=%b TH=%0d want 000/0", {busy, rv, qinj}, th);
    end
    tick(30);
    @(negedge clk);
    total++;
    if (ndone !== d0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_quiet: got done=%0d busy=%b want 0/0", ndone - d0, busy);
    end
  endtask

  initial begin
    set_pat(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    test_reset;
    test_basic_scan;
    test_backpressure;
    test_boundaries;
    test_window_edges;
    test_saturation;
    test_abort;
    test_th50;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
